irq_pending4: RTL
=================

Name: irq_pending4

Overview:
Four-input interrupt pending/latch stage that sits directly upstream of the 4-to-2 priority encoder. It captures request events into sticky pending bits and applies a per-line mask. It drives the masked vector w into the encoder. It runs a small notify/acknowledge FSM toward the CPU side, and clears the serviced bit using the encoder's index (y) returned as ack_id.

Parameters:
EDGE_MODE, 1, 1 = set pending on rising edge of req[i]; 0 = set pending while req[i] is high (level).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  raw request lines, synchronous to clk
mask  input  4  per-line enable, 1 = line may reach w
w  output  4  pending & mask, feeds priority encoder input
ack  input  1  one-cycle service acknowledge from CPU side
ack_id  input  2  index being acknowledged (encoder y)
irq  output  1  interrupt request to CPU side
busy  output  1  high for the one-cycle post-ack holdoff

Behaviour:
- Reset (rst=1 at a clk edge): pending=0, req_q=0, state=IDLE. Outputs irq=0, busy=0, w=0. Reset takes priority over every other event, including reset asserted mid-ASSERT or mid-SERVICE.
- Edge detect: req_q <= req every cycle.
  - EDGE_MODE=1: set_vec = req & ~req_q.
  - EDGE_MODE=0: set_vec = req.
- Pending update per bit i: pending[i] <= set_vec[i] | (pending[i] & ~clr[i]).
  - clr[i] = 1 only when the FSM accepts ack in ASSERT and ack_id == i.
  - A set and a clear of the same bit in the same cycle: set wins, so the bit stays 1 and no event is lost.
- w = pending & mask. This is combinational from the pending register and the mask input. Masked lines keep their pending bit and reappear in w when unmasked.
- Latency: req[i] rises before clk edge k → pending[i]=1 and w[i]=1 after edge k → state=ASSERT and irq=1 after edge k+1.
- FSM states: IDLE, ASSERT, SERVICE (2-bit state register).
  - IDLE: irq=0, busy=0. If |w → ASSERT; otherwise stay.
  - ASSERT: irq=1, busy=0.
    - If ack=1: clear pending[ack_id], then → SERVICE.
    - Else if w==0 (line masked off): → IDLE; irq drops after that edge.
    - Else stay.
    - ack is accepted even when pending[ack_id]=0; it clears nothing and still goes to SERVICE.
  - SERVICE: irq=0, busy=1, unconditional → IDLE. Minimum irq low gap between services is 2 cycles (SERVICE, IDLE).
- ack in IDLE or SERVICE is ignored: no clear, no state change.
- irq and busy are decoded from the state register, so they are glitch-free and registered.
- Encoding: state values IDLE=0, ASSERT=1, SERVICE=2. Value 3 → IDLE on the next edge.

Optional Feature:
IRQ_OVERFLOW_EN
- Defined:
  - Adds output port ovf [3:0].
  - ovf[i] sets when set_vec[i]=1 while pending[i]=1 and clr[i]=0 (a lost duplicate event).
  - ovf[i] clears on rst, or when clr[i]=1 with set_vec[i]=0.
  - Reset value is 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
1. Reset, then req=0001 pulse one cycle (EDGE_MODE=1) → w=0001 one edge later, irq=1 the next edge. ack=1, ack_id=0 → w=0000, busy=1 one cycle, then IDLE with irq=0.
2. req=1010 simultaneously, mask=1111 → w=1010, encoder y=3. ack with ack_id=3 → w=0010, irq re-asserts 2 cycles after the ack. ack_id=1 → w=0000.
3. pending=0100 with mask=1011 → w=0000, irq=0. Set mask=1111 → w=0100 immediately, irq=1 one edge later. Drop mask to 1011 in ASSERT → IDLE, irq=0 after next edge, pending bit 2 retained.
4. New rising edge on req[2] in the same cycle as ack with ack_id=2 → pending[2] stays 1 and irq re-asserts after SERVICE. With IRQ_OVERFLOW_EN: a second edge on req[1] while pending[1]=1 → ovf=0010.
5. rst=1 asserted while in ASSERT with w=0111 → after that edge irq=0, busy=0, w=0000, state IDLE. Holding req=0111 high after reset with EDGE_MODE=1 sets nothing until a new edge.
6. EDGE_MODE=0, req[0] held high through ack → pending[0] re-set on the same edge (set wins), irq returns after 2 cycles. ack during IDLE → no change.

Source files
------------

// File: rtl/irq_pending4_if.sv
// Request/mask/ack bundle between the CPU-side driver and the irq_pending4 latch stage.
// Optional ovf vector exists only when IRQ_OVERFLOW_EN is defined.
interface irq_pending4_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic [3:0] w;
  logic       ack;
  logic [1:0] ack_id;
  logic       irq;
  logic       busy;
`ifdef IRQ_OVERFLOW_EN
  logic [3:0] ovf;

  modport master (output req, mask, ack, ack_id, input w, irq, busy, ovf);
  modport slave  (input req, mask, ack, ack_id, output w, irq, busy, ovf);
`else
  modport master (output req, mask, ack, ack_id, input w, irq, busy);
  modport slave  (input req, mask, ack, ack_id, output w, irq, busy);
`endif
endinterface

// File: rtl/irq_pending4.sv
// Sticky 4-line interrupt pending latch with mask and notify/ack FSM; optional IRQ_OVERFLOW_EN adds ovf.
// Latency: req edge -> w after 1 edge, irq after 2 edges. No backpressure: ack is taken only in ASSERT.
module irq_pending4 #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  irq_pending4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] req_q, req_d;
  logic       irq_q, irq_d;
  logic       busy_q, busy_d;
  logic [3:0] set_vec;
  logic [3:0] clr;
  logic [3:0] w;
  logic       accept;

`ifdef IRQ_OVERFLOW_EN
  logic [3:0] ovf_q, ovf_d;
`endif

  always_comb begin
    req_d   = bus.req;
    set_vec = EDGE_MODE ? (bus.req & ~req_q) : bus.req;
    w       = pending_q & bus.mask;
    accept  = (state_q == ASSERT) && bus.ack;

    // ack is honoured even for a non-pending index; it then clears nothing.
    clr = 4'b0000;
    if (accept) begin
      clr[bus.ack_id] = 1'b1;
    end

    // A simultaneous set beats the clear so no event is dropped.
    pending_d = set_vec | (pending_q & ~clr);

    state_d = state_q;
    case (state_q)
      IDLE:    if (|w) state_d = ASSERT;
      ASSERT: begin
        if (accept)          state_d = SERVICE;
        else if (w == 4'b0)  state_d = IDLE;
      end
      SERVICE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    irq_d  = (state_d == ASSERT);
    busy_d = (state_d == SERVICE);

`ifdef IRQ_OVERFLOW_EN
    ovf_d = (set_vec & pending_q & ~clr) | (ovf_q & ~(clr & ~set_vec));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      req_q     <= 4'b0000;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef IRQ_OVERFLOW_EN
      ovf_q     <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      irq_q     <= irq_d;
      busy_q    <= busy_d;
`ifdef IRQ_OVERFLOW_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign bus.w    = w;
  assign bus.irq  = irq_q;
  assign bus.busy = busy_q;
`ifdef IRQ_OVERFLOW_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
